// File: rtl/dds_voice_ctrl.sv
// rtl/dds_voice_ctrl.sv - shadow/active register file, frame-aligned commit and voice output scanner for the 4-voice DDS core
// Optional per-voice mute selected by `define DDS_CTRL_MUTE_EN.
module dds_voice_ctrl #(
    parameter int SW       = 3,
    parameter int OW       = 12,
    parameter int SLOT_CYC = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wr_en,
    input  logic [3:0]      wr_addr,
    input  logic [7:0]      wr_data,
    input  logic            commit,
    output logic            commit_pending,
    output logic [63:0]     tuning_w,
    output logic [4*SW-1:0] sel_out,
    input  logic [4*OW-1:0] voice_in,
    output logic [OW-1:0]   mux_out,
    output logic [1:0]      mux_voice,
    output logic            frame
);
    localparam int CW = (SLOT_CYC > 2) ? $clog2(SLOT_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SLOT_CYC - 1);

    logic [CW-1:0]   cnt;
    logic [1:0]      voice;
    logic [1:0]      voice_nxt;
    logic            slot_edge;
    logic            load;
    logic [OW-1:0]   sample;
    logic [63:0]     tw_sh;
    logic [4*SW-1:0] sel_sh;

    assign slot_edge = (cnt == CNT_LAST);
    assign voice_nxt = voice + 2'd1;
    assign frame     = (voice == 2'd0) && (cnt == '0);
    // The edge leaving voice 3 is the edge that raises frame, so the load lands with it.
    assign load      = slot_edge && (voice == 2'd3) && commit_pending;

`ifdef DDS_CTRL_MUTE_EN
    localparam logic [OW-1:0] MIDSCALE = {1'b1, {(OW-1){1'b0}}};
    logic [3:0] mute_sh;
    logic [3:0] mute_act;

    assign sample = mute_act[voice_nxt] ? MIDSCALE : voice_in[int'(voice_nxt)*OW +: OW];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mute_act <= '0;
        end else if (load) begin
            mute_act <= mute_sh;
        end
    end
`else
    assign sample = voice_in[int'(voice_nxt)*OW +: OW];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            voice     <= 2'd0;
            mux_out   <= '0;
            mux_voice <= 2'd0;
        end else if (slot_edge) begin
            cnt       <= '0;
            voice     <= voice_nxt;
            mux_out   <= sample;
            mux_voice <= voice_nxt;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tw_sh  <= '0;
            sel_sh <= '0;
`ifdef DDS_CTRL_MUTE_EN
            mute_sh <= '0;
`endif
        end else if (wr_en) begin
            case (wr_addr[1:0])
                2'd0:    tw_sh[{wr_addr[3:2], 4'b0000} +: 8] <= wr_data;
                2'd1:    tw_sh[{wr_addr[3:2], 4'b1000} +: 8] <= wr_data;
                2'd2:    sel_sh[int'(wr_addr[3:2])*SW +: SW] <= wr_data[SW-1:0];
`ifdef DDS_CTRL_MUTE_EN
                default: mute_sh[wr_addr[3:2]] <= wr_data[0];
`else
                default: ;
`endif
            endcase
        end
    end

    // Load wins over a coincident commit, so a re-request while armed never double-loads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            commit_pending <= 1'b0;
            tuning_w       <= '0;
            sel_out        <= '0;
        end else if (load) begin
            commit_pending <= 1'b0;
            tuning_w       <= tw_sh;
            sel_out        <= sel_sh;
        end else if (commit) begin
            commit_pending <= 1'b1;
        end
    end
endmodule

// File: tb/tb_dds_voice_ctrl.sv
// tb/tb_dds_voice_ctrl.sv - randomized self-checking bench for dds_voice_ctrl against a frame-arithmetic reference model
module tb_dds_voice_ctrl;
    localparam int SW = 3;
    localparam int OW = 12;
    localparam int SC = 4;
    localparam int FR = 4 * SC;
    localparam int BW = OW + 2 + 1 + 1 + 64 + 4 * SW;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            wr_en = 1'b0;
    logic [3:0]      wr_addr = '0;
    logic [7:0]      wr_data = '0;
    logic            commit = 1'b0;
    logic            commit_pending;
    logic [63:0]     tuning_w;
    logic [4*SW-1:0] sel_out;
    logic [4*OW-1:0] voice_in = '0;
    logic [OW-1:0]   mux_out;
    logic [1:0]      mux_voice;
    logic            frame;
    logic [BW-1:0]   got;

    dds_voice_ctrl #(.SW(SW), .OW(OW), .SLOT_CYC(SC)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .commit(commit), .commit_pending(commit_pending), .tuning_w(tuning_w),
        .sel_out(sel_out), .voice_in(voice_in), .mux_out(mux_out),
        .mux_voice(mux_voice), .frame(frame)
    );

    always #5 clk = ~clk;
    assign got = {mux_out, mux_voice, frame, commit_pending, tuning_w, sel_out};

    int checks = 0;
    int passed = 0;

    // Reference model: t counts cycles since reset release; slot and frame position follow from t.
    int            t;
    logic [15:0]   m_tw [4];
    logic [15:0]   s_tw [4];
    logic [SW-1:0] m_sel [4];
    logic [SW-1:0] s_sel [4];
    logic          m_mute [4];
    logic          s_mute [4];
    logic          m_pend;
    logic [OW-1:0] m_mux;
    logic [1:0]    m_mv;

    task automatic model_reset();
        t = 0; m_pend = 1'b0; m_mux = '0; m_mv = 2'd0;
        for (int v = 0; v < 4; v++) begin
            m_tw[v] = '0; s_tw[v] = '0; m_sel[v] = '0; s_sel[v] = '0; m_mute[v] = 1'b0; s_mute[v] = 1'b0;
        end
    endtask

    task automatic model_edge();
        int nt = t + 1;
        int nv = (nt / SC) % 4;
        int v  = int'(wr_addr[3:2]);
        bit enter = (nt % SC) == 0;
        if (enter) begin
            m_mux = m_mute[nv] ? {1'b1, {(OW-1){1'b0}}} : voice_in[nv*OW +: OW];
            m_mv  = 2'(nv);
        end
        if (enter && nv == 0 && m_pend) begin
            for (int i = 0; i < 4; i++) begin
                m_tw[i] = s_tw[i]; m_sel[i] = s_sel[i]; m_mute[i] = s_mute[i];
            end
            m_pend = 1'b0;
        end else if (commit) begin
            m_pend = 1'b1;
        end
        if (wr_en) begin
            case (wr_addr[1:0])
                2'd0: s_tw[v][7:0]  = wr_data;
                2'd1: s_tw[v][15:8] = wr_data;
                2'd2: s_sel[v]      = wr_data[SW-1:0];
                default: begin
`ifdef DDS_CTRL_MUTE_EN
                    s_mute[v] = wr_data[0];
`endif
                end
            endcase
        end
        t = nt;
    endtask

    function automatic logic [BW-1:0] exp_bus();
        logic [63:0]     tw;
        logic [4*SW-1:0] sl;
        for (int v = 0; v < 4; v++) begin
            tw[16*v +: 16] = m_tw[v];
            sl[SW*v +: SW] = m_sel[v];
        end
        return {m_mux, m_mv, (t % FR) == 0, m_pend, tw, sl};
    endfunction

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        wr_en = 1'b0;
        commit = 1'b0;
    endtask

    task automatic put_write(input logic [1:0] v, input logic [1:0] f, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = {v, f}; wr_data = d;
        cyc();
    endtask

    task automatic run_to(input int p);
        for (int i = 0; i < 2 * FR && (t % FR) != p; i++) cyc();
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (got !== {{OW{1'b0}}, 2'd0, 1'b1, 1'b0, 64'h0, {(4*SW){1'b0}}})
            $display("FAIL reset_held got=%h exp=frame-only", got);
        else passed++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        checks++;
        if (frame !== 1'b1 || got !== exp_bus())
            $display("FAIL reset_release got=%h exp=%h", got, exp_bus());
        else passed++;
    endtask

    task automatic test_scanner();
        int frames = 0;
        voice_in = {12'h333, 12'h222, 12'h111, 12'h000};
        repeat (3 * FR) begin
            cyc();
            checks++;
            if (got !== exp_bus()) $display("FAIL scanner t=%0d got=%h exp=%h", t, got, exp_bus());
            else passed++;
            if (frame) frames++;
        end
        checks++;
        if (frames !== 3) $display("FAIL scanner_frames got=%0d exp=3", frames);
        else passed++;
    endtask

    task automatic test_commit();
        run_to(2);
        put_write(2'd2, 2'd0, 8'h34);
        put_write(2'd2, 2'd1, 8'h12);
        put_write(2'd2, 2'd2, 8'h05);
        commit = 1'b1;
        cyc();
        while ((t % FR) != 0) begin
            checks++;
            if (tuning_w[47:32] !== 16'h0 || sel_out[8:6] !== 3'd0 || commit_pending !== 1'b1)
                $display("FAIL commit_early t=%0d got=%h/%h/%b exp=0/0/1", t, tuning_w[47:32], sel_out[8:6], commit_pending);
            else passed++;
            cyc();
        end
        checks++;
        if (tuning_w[47:32] !== 16'h1234 || sel_out[8:6] !== 3'd5 || commit_pending !== 1'b0)
            $display("FAIL commit_load got=%h/%h/%b exp=1234/5/0", tuning_w[47:32], sel_out[8:6], commit_pending);
        else passed++;
    endtask

    task automatic test_commit_on_frame();
        logic [7:0] b = 8'($urandom_range(1, 255));
        run_to(10);
        put_write(2'd1, 2'd0, b);
        run_to(0);
        checks++;
        if (frame !== 1'b1) $display("FAIL cof_frame got=%b exp=1", frame);
        else passed++;
        commit = 1'b1;
        cyc();
        checks++;
        if (commit_pending !== 1'b1 || tuning_w[23:16] !== 8'h00)
            $display("FAIL cof_armed got=%b/%h exp=1/00", commit_pending, tuning_w[23:16]);
        else passed++;
        repeat (FR - 1) cyc();
        checks++;
        if (got !== exp_bus() || tuning_w[23:16] !== b || commit_pending !== 1'b0)
            $display("FAIL cof_load got=%h/%b exp=%h/0", tuning_w[23:16], commit_pending, b);
        else passed++;
    endtask

    task automatic test_write_on_edge();
        run_to(3);
        commit = 1'b1;
        cyc();
        run_to(FR - 2);
        put_write(2'd0, 2'd0, 8'hAA);
        put_write(2'd0, 2'd0, 8'hBB);
        checks++;
        if (tuning_w[7:0] !== 8'hAA || commit_pending !== 1'b0)
            $display("FAIL woe_load got=%h/%b exp=aa/0", tuning_w[7:0], commit_pending);
        else passed++;
        repeat (FR) cyc();
        checks++;
        if (tuning_w[7:0] !== 8'hAA) $display("FAIL woe_hold got=%h exp=aa", tuning_w[7:0]);
        else passed++;
        commit = 1'b1;
        cyc();
        repeat (FR) cyc();
        checks++;
        if (tuning_w[7:0] !== 8'hBB || got !== exp_bus())
            $display("FAIL woe_next got=%h exp=bb", tuning_w[7:0]);
        else passed++;
    endtask

    task automatic test_random();
        repeat (400) begin
            voice_in = 48'({$urandom(), $urandom()});
            wr_en    = ($urandom_range(0, 2) == 0);
            wr_addr  = 4'($urandom_range(0, 15));
            wr_data  = 8'($urandom());
            commit   = ($urandom_range(0, 9) == 0);
            cyc();
            checks++;
            if (got !== exp_bus()) $display("FAIL random t=%0d got=%h exp=%h", t, got, exp_bus());
            else passed++;
        end
    endtask

    task automatic test_reset_midpending();
        run_to(4);
        put_write(2'd3, 2'd1, 8'hC3);
        commit = 1'b1;
        cyc();
        checks++;
        if (commit_pending !== 1'b1) $display("FAIL rmp_armed got=%b exp=1", commit_pending);
        else passed++;
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (got !== {{OW{1'b0}}, 2'd0, 1'b1, 1'b0, 64'h0, {(4*SW){1'b0}}})
            $display("FAIL rmp_async got=%h exp=frame-only", got);
        else passed++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        checks++;
        if (got !== exp_bus()) $display("FAIL rmp_release got=%h exp=%h", got, exp_bus());
        else passed++;
        commit = 1'b1;
        cyc();
        repeat (2 * FR) cyc();
        checks++;
        if (tuning_w !== 64'h0 || commit_pending !== 1'b0)
            $display("FAIL rmp_cleared got=%h/%b exp=0/0", tuning_w, commit_pending);
        else passed++;
    endtask

    task automatic test_mute();
        logic [OW-1:0] v1_exp;
`ifdef DDS_CTRL_MUTE_EN
        v1_exp = 12'h800;
`else
        v1_exp = 12'h111;
`endif
        voice_in = {12'h333, 12'h222, 12'h111, 12'h000};
        run_to(2);
        put_write(2'd1, 2'd3, 8'h01);
        commit = 1'b1;
        cyc();
        run_to(1);
        repeat (2 * FR) begin
            cyc();
            checks++;
            if (got !== exp_bus()) $display("FAIL mute_bus t=%0d got=%h exp=%h", t, got, exp_bus());
            else passed++;
            if (m_mv == 2'd1) begin
                checks++;
                if (mux_out !== v1_exp) $display("FAIL mute_v1 got=%h exp=%h", mux_out, v1_exp);
                else passed++;
            end else if (m_mv == 2'd2) begin
                checks++;
                if (mux_out !== 12'h222) $display("FAIL mute_v2 got=%h exp=222", mux_out);
                else passed++;
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_scanner();
        test_commit();
        test_commit_on_frame();
        test_write_on_edge();
        test_random();
        test_reset_midpending();
        test_mute();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
